bullet_pool: RTL and testbench

BULLET_POOL -- requirements
Module: bullet_pool

---
 rtl/bullet_pool.sv | 180 ++++++++++++++++++
 tb/tb_bullet_pool.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_pool.sv
// Pool of independent bullet slots: fire-edge capture, cooldown, per-frame motion,
// screen-edge retirement, opponent collision with hit counting, and pixel overlay.
module bullet_pool #(
  parameter int          NUM_BULLETS   = 4,
  parameter int          BULLET_SPEED  = 2,
  parameter int          COOLDOWN      = 8,
  parameter int          SCREEN_WIDTH  = 640,
  parameter int          SCREEN_HEIGHT = 480,
  parameter int          BULLET_SIZE   = 4,
  parameter int          TARGET_SIZE   = 32,
  parameter logic [11:0] BULLET_COLOR  = 12'hFF0,
  parameter logic [11:0] KEY_COLOR     = 12'h000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   fire,
  input  logic [1:0]             orientation,
  input  logic [10:0]            sprite_x,
  input  logic [10:0]            sprite_y,
  input  logic [10:0]            opponent_x,
  input  logic [10:0]            opponent_y,
  input  logic [10:0]            x,
  input  logic [10:0]            y,
  input  logic [11:0]            si_rgb,
  output logic [11:0]            so_rgb,
  output logic [NUM_BULLETS-1:0] active_mask,
  output logic                   hit_pulse,
  output logic [7:0]             hit_count
);

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  localparam int          CD_W  = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [11:0] SPEED = 12'(BULLET_SPEED);
  localparam logic [11:0] LIM_X = 12'(SCREEN_WIDTH - BULLET_SIZE);
  localparam logic [11:0] LIM_Y = 12'(SCREEN_HEIGHT - BULLET_SIZE);
  localparam logic [11:0] BSZ   = 12'(BULLET_SIZE);
  localparam logic [11:0] TSZ   = 12'(TARGET_SIZE);

  logic [NUM_BULLETS-1:0] active_q, active_d;
  logic [10:0]            pos_x_q [NUM_BULLETS];
  logic [10:0]            pos_x_d [NUM_BULLETS];
  logic [10:0]            pos_y_q [NUM_BULLETS];
  logic [10:0]            pos_y_d [NUM_BULLETS];
  dir_e                   dir_q   [NUM_BULLETS];
  dir_e                   dir_d   [NUM_BULLETS];
  logic                   pending_q, pending_d;
  logic                   fire_prev_q, fire_prev_d;
  logic [CD_W-1:0]        cd_q, cd_d;
  logic                   hit_pulse_q, hit_pulse_d;
  logic [7:0]             hit_count_q, hit_count_d;

  logic [11:0] bx, by, nx, ny, ox, oy;
  logic        off_screen, slot_found, take_shot, any_hit, fire_edge;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    active_d    = active_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    dir_d       = dir_q;
    pending_d   = pending_q;
    fire_prev_d = fire;
    cd_d        = cd_q;
    hit_pulse_d = 1'b0;
    hit_count_d = hit_count_q;
    bx          = '0;
    by          = '0;
    nx          = '0;
    ny          = '0;
    off_screen  = 1'b0;
    slot_found  = 1'b0;
    any_hit     = 1'b0;
    fire_edge   = fire & ~fire_prev_q;
    take_shot   = pending_q && (cd_q == '0);
    ox          = {1'b0, opponent_x};
    oy          = {1'b0, opponent_y};

    if (frame_tick) begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (active_q[i]) begin
          bx = {1'b0, pos_x_q[i]};
          by = {1'b0, pos_y_q[i]};
          nx = bx;
          ny = by;
          case (dir_q[i])
            DIR_UP:   begin off_screen = by < SPEED;           ny = by - SPEED; end
            DIR_DOWN: begin off_screen = (by + SPEED) > LIM_Y; ny = by + SPEED; end
            DIR_LEFT: begin off_screen = bx < SPEED;           nx = bx - SPEED; end
            default:  begin off_screen = (bx + SPEED) > LIM_X; nx = bx + SPEED; end
          endcase
          if (off_screen) begin
            active_d[i] = 1'b0;
          end else begin
            pos_x_d[i] = nx[10:0];
            pos_y_d[i] = ny[10:0];
            // Collision uses the moved position, in 12 bits so box edges never wrap.
            if (nx < ox + TSZ && ox < nx + BSZ && ny < oy + TSZ && oy < ny + BSZ) begin
              active_d[i] = 1'b0;
              any_hit     = 1'b1;
            end
          end
        end else if (!slot_found) begin
          // Only slots already free before this tick are candidates; a fresh slot does not move yet.
          slot_found = 1'b1;
          if (take_shot) begin
            active_d[i] = 1'b1;
            pos_x_d[i]  = sprite_x;
            pos_y_d[i]  = sprite_y;
            dir_d[i]    = dir_e'(orientation);
          end
        end
      end

      if (pending_q) pending_d = 1'b0;
      if (take_shot && slot_found) cd_d = CD_W'(COOLDOWN);
      else if (cd_q != '0)         cd_d = cd_q - CD_W'(1);

      hit_pulse_d = any_hit;
      if (any_hit && hit_count_q != 8'hFF) hit_count_d = hit_count_q + 8'd1;
    end

    if (fire_edge && !pending_q) pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= '0;
      // NOTE: the slot registers are plain flops, not a RAM, so clearing them on reset is legal and cheap.
      for (int i = 0; i < NUM_BULLETS; i++) begin
        pos_x_q[i] <= '0;
        pos_y_q[i] <= '0;
        dir_q[i]   <= DIR_UP;
      end
      pending_q   <= 1'b0;
      fire_prev_q <= 1'b0;
      cd_q        <= '0;
      hit_pulse_q <= 1'b0;
      hit_count_q <= '0;
    end else begin
      active_q    <= active_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      dir_q       <= dir_d;
      pending_q   <= pending_d;
      fire_prev_q <= fire_prev_d;
      cd_q        <= cd_d;
      hit_pulse_q <= hit_pulse_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign active_mask = active_q;
  assign hit_pulse   = hit_pulse_q;
  assign hit_count   = hit_count_q;

  logic        pix_hit;
  logic [11:0] px, py;

  always_comb begin
    pix_hit = 1'b0;
    px      = {1'b0, x};
    py      = {1'b0, y};
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (active_q[i] &&
          px >= {1'b0, pos_x_q[i]} && px < {1'b0, pos_x_q[i]} + BSZ &&
          py >= {1'b0, pos_y_q[i]} && py < {1'b0, pos_y_q[i]} + BSZ) begin
        pix_hit = 1'b1;
      end
    end
    so_rgb = (pix_hit && BULLET_COLOR != KEY_COLOR) ? BULLET_COLOR : si_rgb;
  end

endmodule

// File: tb/tb_bullet_pool.sv
// Bench for bullet_pool: directed scenarios plus randomized traffic, all checked
// against a frame-level behavioural model of the bullet pool.
module tb_bullet_pool;

  localparam int NB  = 4;
  localparam int SPD = 2;
  localparam int CD  = 8;
  localparam int W   = 640;
  localparam int H   = 480;
  localparam int BS  = 4;
  localparam int TS  = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_tick;
  logic          fire;
  logic [1:0]    orientation;
  logic [10:0]   sprite_x, sprite_y, opponent_x, opponent_y, x, y;
  logic [11:0]   si_rgb, so_rgb;
  logic [NB-1:0] active_mask;
  logic          hit_pulse;
  logic [7:0]    hit_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bullet_pool #(
    .NUM_BULLETS(NB), .BULLET_SPEED(SPD), .COOLDOWN(CD),
    .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .BULLET_SIZE(BS), .TARGET_SIZE(TS),
    .BULLET_COLOR(12'hFF0), .KEY_COLOR(12'h000)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .fire(fire),
    .orientation(orientation), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .opponent_x(opponent_x), .opponent_y(opponent_y), .x(x), .y(y),
    .si_rgb(si_rgb), .so_rgb(so_rgb), .active_mask(active_mask),
    .hit_pulse(hit_pulse), .hit_count(hit_count)
  );

  // Reference model: whole-frame behaviour with plain integer arithmetic.
  bit m_act [NB];
  int m_x   [NB];
  int m_y   [NB];
  int m_dir [NB];
  bit m_pend, m_prev, m_pulse;
  int m_cd, m_hits;

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0;
    end
    m_pend = 0; m_prev = 0; m_pulse = 0; m_cd = 0; m_hits = 0;
  endtask

  function automatic logic [NB-1:0] m_mask();
    logic [NB-1:0] r = '0;
    for (int i = 0; i < NB; i++) r[i] = m_act[i];
    return r;
  endfunction

  function automatic logic [11:0] m_rgb(int px, int py, logic [11:0] bg);
    for (int i = 0; i < NB; i++)
      if (m_act[i] && px >= m_x[i] && px < m_x[i] + BS && py >= m_y[i] && py < m_y[i] + BS)
        return 12'hFF0;
    return bg;
  endfunction

  task automatic model_clock();
    bit edge_now = fire && !m_prev;
    bit pend_old = m_pend;
    bit was_act [NB];
    bit hit = 0;
    int free_slot = -1;
    int nx, ny;
    m_prev  = fire;
    m_pulse = 0;
    if (frame_tick) begin
      for (int i = 0; i < NB; i++) was_act[i] = m_act[i];
      for (int i = 0; i < NB; i++) if (!was_act[i] && free_slot < 0) free_slot = i;
      for (int i = 0; i < NB; i++) begin
        if (was_act[i]) begin
          nx = m_x[i]; ny = m_y[i];
          case (m_dir[i])
            0: ny -= SPD;
            1: ny += SPD;
            2: nx -= SPD;
            default: nx += SPD;
          endcase
          // A bullet whose box would leave the screen retires instead of moving.
          if (nx < 0 || ny < 0 || nx > W - BS || ny > H - BS) m_act[i] = 0;
          else begin
            m_x[i] = nx; m_y[i] = ny;
            if (nx < opponent_x + TS && opponent_x < nx + BS &&
                ny < opponent_y + TS && opponent_y < ny + BS) begin
              m_act[i] = 0; hit = 1;
            end
          end
        end
      end
      if (pend_old && m_cd == 0 && free_slot >= 0) begin
        m_act[free_slot] = 1;
        m_x[free_slot]   = int'(sprite_x);
        m_y[free_slot]   = int'(sprite_y);
        m_dir[free_slot] = int'(orientation);
        m_cd = CD;
      end else if (m_cd > 0) m_cd--;
      if (pend_old) m_pend = 0;
      if (hit) begin
        m_pulse = 1;
        if (m_hits < 255) m_hits++;
      end
    end
    if (edge_now && !pend_old) m_pend = 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic tick_frames(int n);
    repeat (n) begin
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
    end
  endtask

  task automatic press();
    fire = 1'b1; step();
    fire = 1'b0; step();
  endtask

  task automatic do_reset();
    reset = 1'b1; frame_tick = 1'b0; fire = 1'b0;
    @(negedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    x = 11'd0; y = 11'd0; si_rgb = 12'h123; #1;
    checks++; if (active_mask !== '0) begin errors++; $display("FAIL reset_mask: got %b want 0", active_mask); end
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", hit_pulse); end
    checks++; if (hit_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", hit_count); end
    checks++; if (so_rgb !== 12'h123) begin errors++; $display("FAIL reset_rgb: got %h want 123", so_rgb); end
  endtask

  task automatic test_fire_right();
    do_reset();
    opponent_x = 11'd500; opponent_y = 11'd400;
    sprite_x = 11'd100; sprite_y = 11'd200; orientation = 2'b11;
    press(); tick_frames(1);
    checks++; if (active_mask !== 4'b0001) begin errors++; $display("FAIL fire_alloc: got %b want 0001", active_mask); end
    x = 11'd101; y = 11'd201; si_rgb = 12'h0AB; #1;
    checks++; if (so_rgb !== 12'hFF0) begin errors++; $display("FAIL fire_pix_in: got %h want ff0", so_rgb); end
    tick_frames(3);
    x = 11'd106; y = 11'd200; #1;
    checks++; if (so_rgb !== 12'hFF0) begin errors++; $display("FAIL fire_x106: got %h want ff0", so_rgb); end
    x = 11'd105; #1;
    checks++; if (so_rgb !== 12'h0AB) begin errors++; $display("FAIL fire_x105: got %h want 0ab", so_rgb); end
    x = 11'd110; #1;
    checks++; if (so_rgb !== 12'h0AB) begin errors++; $display("FAIL fire_x110: got %h want 0ab", so_rgb); end
  endtask

  task automatic test_cooldown();
    do_reset();
    opponent_x = 11'd500; opponent_y = 11'd400;
    sprite_x = 11'd100; sprite_y = 11'd200; orientation = 2'b11;
    fire = 1'b1; step();
    tick_frames(10);
    checks++; if (active_mask !== 4'b0001) begin errors++; $display("FAIL cd_held: got %b want 0001", active_mask); end
    fire = 1'b0; step();
    press(); tick_frames(1);
    checks++; if (active_mask !== 4'b0011) begin errors++; $display("FAIL cd_repress: got %b want 0011", active_mask); end
    // A press while cooldown is running is dropped.
    press(); tick_frames(1);
    checks++; if (active_mask !== 4'b0011) begin errors++; $display("FAIL cd_drop: got %b want 0011", active_mask); end
    checks++; if (active_mask !== m_mask()) begin errors++; $display("FAIL cd_model: got %b want %b", active_mask, m_mask()); end
  endtask

  task automatic test_pool_full();
    do_reset();
    opponent_x = 11'd600; opponent_y = 11'd0;
    sprite_y = 11'd300; orientation = 2'b00;
    for (int k = 0; k < 4; k++) begin
      sprite_x = 11'(100 + 100 * k);
      press(); tick_frames(9);
    end
    checks++; if (active_mask !== 4'b1111) begin errors++; $display("FAIL full_four: got %b want 1111", active_mask); end
    sprite_x = 11'd500;
    press(); tick_frames(1);
    checks++; if (active_mask !== 4'b1111) begin errors++; $display("FAIL full_drop: got %b want 1111", active_mask); end
    // Free slot 0 by steering the opponent into its path, then shoot at once.
    opponent_x = 11'(m_x[0]); opponent_y = 11'(m_y[0] - SPD);
    tick_frames(1);
    checks++; if (active_mask !== 4'b1110) begin errors++; $display("FAIL full_freed: got %b want 1110", active_mask); end
    opponent_x = 11'd600; opponent_y = 11'd0;
    press(); tick_frames(1);
    checks++; if (active_mask !== 4'b1111) begin errors++; $display("FAIL full_no_reload: got %b want 1111", active_mask); end
    checks++; if (hit_count !== 8'(m_hits)) begin errors++; $display("FAIL full_count: got %0d want %0d", hit_count, m_hits); end
  endtask

  task automatic test_boundary();
    do_reset();
    opponent_x = 11'd600; opponent_y = 11'd400; si_rgb = 12'h055;
    sprite_x = 11'd300; sprite_y = 11'd3; orientation = 2'b00;
    press(); tick_frames(1); tick_frames(1);
    x = 11'd300; y = 11'd1; #1;
    checks++; if (so_rgb !== 12'hFF0) begin errors++; $display("FAIL bnd_up_y1: got %h want ff0", so_rgb); end
    checks++; if (active_mask !== 4'b0001) begin errors++; $display("FAIL bnd_up_live: got %b want 0001", active_mask); end
    tick_frames(1);
    checks++; if (active_mask !== 4'b0000) begin errors++; $display("FAIL bnd_up_gone: got %b want 0000", active_mask); end
    tick_frames(8);
    sprite_x = 11'd634; sprite_y = 11'd100; orientation = 2'b11;
    press(); tick_frames(2);
    checks++; if (active_mask !== 4'b0001) begin errors++; $display("FAIL bnd_right_636: got %b want 0001", active_mask); end
    tick_frames(1);
    checks++; if (active_mask !== 4'b0000) begin errors++; $display("FAIL bnd_right_gone: got %b want 0000", active_mask); end
  endtask

  task automatic test_hit();
    do_reset();
    opponent_x = 11'd120; opponent_y = 11'd190;
    sprite_x = 11'd100; sprite_y = 11'd200; orientation = 2'b11;
    press(); tick_frames(1); tick_frames(8);
    checks++; if (active_mask !== 4'b0001 || hit_count !== 8'd0) begin
      errors++; $display("FAIL hit_pre: mask %b count %0d want 0001/0", active_mask, hit_count); end
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    checks++; if (hit_pulse !== 1'b1) begin errors++; $display("FAIL hit_pulse_on: got %b want 1", hit_pulse); end
    checks++; if (hit_count !== 8'd1) begin errors++; $display("FAIL hit_count1: got %0d want 1", hit_count); end
    checks++; if (active_mask !== 4'b0000) begin errors++; $display("FAIL hit_freed: got %b want 0000", active_mask); end
    step();
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("FAIL hit_pulse_off: got %b want 0", hit_pulse); end
  endtask

  task automatic test_saturation();
    do_reset();
    opponent_x = 11'd104; opponent_y = 11'd200;
    sprite_x = 11'd100; sprite_y = 11'd200; orientation = 2'b11;
    for (int k = 0; k < 260; k++) begin
      press(); tick_frames(10);
      if (k == 100) begin
        checks++; if (hit_count !== 8'(m_hits)) begin errors++; $display("FAIL sat_mid: got %0d want %0d", hit_count, m_hits); end
      end
    end
    checks++; if (hit_count !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d want 255", hit_count); end
    checks++; if (active_mask !== 4'b0000) begin errors++; $display("FAIL sat_mask: got %b want 0000", active_mask); end
  endtask

  task automatic test_render();
    int px [6] = '{101, 104, 100, 103, 99, 100};
    int py [6] = '{201, 200, 200, 203, 200, 204};
    bit on [6] = '{1, 0, 1, 1, 0, 0};
    do_reset();
    opponent_x = 11'd600; opponent_y = 11'd400;
    sprite_x = 11'd100; sprite_y = 11'd200; orientation = 2'b00;
    press(); tick_frames(1);
    for (int k = 0; k < 6; k++) begin
      x = 11'(px[k]); y = 11'(py[k]); si_rgb = 12'h3C7; #1;
      checks++;
      if (so_rgb !== (on[k] ? 12'hFF0 : 12'h3C7)) begin
        errors++; $display("FAIL render_%0d_%0d: got %h want %h", px[k], py[k], so_rgb, on[k] ? 12'hFF0 : 12'h3C7);
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    opponent_x = 11'd600; opponent_y = 11'd400;
    sprite_x = 11'd200; sprite_y = 11'd100; orientation = 2'b01;
    press(); tick_frames(3);
    #2 reset = 1'b1; #1;
    x = 11'd200; y = 11'd104; si_rgb = 12'h777; #1;
    checks++; if (active_mask !== 4'b0000) begin errors++; $display("FAIL mid_async_mask: got %b want 0000", active_mask); end
    checks++; if (so_rgb !== 12'h777) begin errors++; $display("FAIL mid_async_rgb: got %h want 777", so_rgb); end
    model_reset();
    @(negedge clk); reset = 1'b0;
    press(); tick_frames(1);
    checks++; if (active_mask !== 4'b0001) begin errors++; $display("FAIL mid_after: got %b want 0001", active_mask); end
  endtask

  task automatic test_random();
    int r, pxr, pyr;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 256 == 0) begin
        opponent_x = 11'($urandom_range(0, W - TS)); opponent_y = 11'($urandom_range(0, H - TS));
      end
      if (cyc == 1500) do_reset();
      frame_tick  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) fire = ~fire;
      orientation = 2'($urandom_range(0, 3));
      sprite_x    = 11'($urandom_range(0, W - BS));
      sprite_y    = 11'($urandom_range(0, H - BS));
      step();
      r = $urandom_range(0, NB - 1);
      if (m_act[r]) begin
        pxr = m_x[r] + $urandom_range(0, BS); pyr = m_y[r] + $urandom_range(0, BS);
      end else begin
        pxr = $urandom_range(0, W - 1); pyr = $urandom_range(0, H - 1);
      end
      x = 11'(pxr); y = 11'(pyr); si_rgb = 12'($urandom); #1;
      checks++; if (active_mask !== m_mask()) begin errors++; $display("FAIL rnd_mask@%0d: got %b want %b", cyc, active_mask, m_mask()); end
      checks++; if (hit_pulse !== m_pulse) begin errors++; $display("FAIL rnd_pulse@%0d: got %b want %b", cyc, hit_pulse, m_pulse); end
      checks++; if (hit_count !== 8'(m_hits)) begin errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, hit_count, m_hits); end
      checks++; if (so_rgb !== m_rgb(pxr, pyr, si_rgb)) begin
        errors++; $display("FAIL rnd_rgb@%0d (%0d,%0d): got %h want %h", cyc, pxr, pyr, so_rgb, m_rgb(pxr, pyr, si_rgb)); end
    end
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; fire = 1'b0; orientation = 2'b00;
    sprite_x = '0; sprite_y = '0; opponent_x = '0; opponent_y = '0;
    x = '0; y = '0; si_rgb = '0;
    test_reset();
    test_fire_right();
    test_cooldown();
    test_pool_full();
    test_boundary();
    test_hit();
    test_saturation();
    test_render();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
